alu: RTL and testbench
======================

Name: alu

Overview:
- Parameterised registered ALU with eight 3-bit-encoded operations: AND, OR, ADD, AND-NOT, OR-NOT, SUBTRACT, signed set-less-than, and one reserved code.
- Operands are sampled with a valid strobe; result and flags are registered, giving one cycle of latency.
- Serves as the arithmetic/logic execute stage of the datapath calculator.

Parameters:
- WIDTH, 4, operand and result width in bits (legal values ≥2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and control valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- control  input  3  operation select
- res  output  WIDTH  registered result
- carry_out  output  1  registered carry flag
- overflow  output  1  registered signed-overflow flag (ADD/SUB only)
- zero  output  1  registered flag, high when res is 0
- out_valid  output  1  high for one cycle when res and flags hold a new result

Behaviour:
- Reset: while rst_n=0 (asynchronous assertion, synchronous to clk on release), res=0, carry_out=0, overflow=0, zero=0, out_valid=0.
- Latency: inputs sampled on the rising clk edge where in_valid=1; results appear on the outputs after that edge. out_valid=1 during the following cycle. Back-to-back in_valid gives one result per cycle.
- When in_valid=0: out_valid goes to 0; res and all flags hold their last values.
- Datapath: one shared WIDTH-bit adder computes a + bmux + cin.
  - For control[2]=1: bmux = ~b and cin = 1.
  - For control[2]=0: bmux = b and cin = 0.
- Operation encoding:
  - 000 AND: res = a & b
  - 001 OR: res = a | b
  - 010 ADD: res = (a + b) mod 2^WIDTH; carry_out = carry out of the MSB
  - 011 reserved: res = 0, all flags 0 except zero=1
  - 100 AND_NOT_B: res = a & ~b
  - 101 OR_NOT_B: res = a | ~b
  - 110 SUBTRACT: res = (a + ~b + 1) mod 2^WIDTH; carry_out = carry out of the MSB (1 means no borrow, i.e. a ≥ b unsigned)
  - 111 SLT: res = 1 (zero-extended) if signed(a) < signed(b), else 0. Computed as sum[MSB] XOR overflow of the subtraction, so it is correct across overflow.
- Flag rules:
  - carry_out = 0 for every code other than 010 and 110.
  - overflow = two's-complement signed overflow for 010 and 110; 0 otherwise, including SLT.
  - zero = (res == 0) for every code.
- Boundary cases:
  - WIDTH-bit wrap on ADD/SUB is silent except through the flags.
  - Reset asserted mid-operation discards the pending result; out_valid stays 0 until a new in_valid is sampled after reset release.
  - X or undefined control values are not supported; any code not listed above does not exist, since all 8 codes are defined.

Test Plan:
- Reset: hold rst_n=0, then pulse in_valid with ADD 3+5 while still in reset -> res=0000, all flags 0, out_valid=0. Release reset, apply ADD 0011+0101 -> next cycle res=1000, carry_out=0, overflow=1, out_valid=1.
- Logic ops:
  - AND 1100&1010 -> 1000
  - OR 0001|0011 -> 0011
  - AND_NOT_B 1100,1010 -> 0100
  - OR_NOT_B 0011,0001 -> 1111
  - AND 1111&0000 -> 0000 with zero=1
  - carry_out=0 for all of the above
- ADD edges:
  - 1111+0001 -> 0000, carry_out=1, zero=1, overflow=0
  - 1000+1000 -> 0000, carry_out=1, overflow=1
  - 1111+1111 -> 1110, carry_out=1
  - 0000+0000 -> 0000, zero=1
- SUBTRACT:
  - 0101-0011 -> 0010, carry_out=1
  - 1000-0011 -> 0101, overflow=1, carry_out=1
  - 0001-0010 -> 1111, carry_out=0
  - 0000-0001 -> 1111, carry_out=0
  - 0000-0000 -> 0000, carry_out=1, zero=1
- SLT:
  - 0011,0110 -> 0001
  - 0110,0011 -> 0000 with zero=1
  - 1000,0111 -> 0001 (signed −8<7 despite subtraction overflow)
  - overflow=0 and carry_out=0 in every SLT case
- Streaming and hold: drive 3 consecutive in_valid cycles (ADD, SUB, SLT) -> 3 consecutive out_valid cycles with matching results. Then deassert in_valid -> out_valid=0, res holds the SLT value. Code 011 -> res=0000, zero=1.

Source files
------------

// File: rtl/alu.sv
// Registered ALU execute stage: eight 3-bit operations share one adder.
// Operands are captured on an in_valid edge; result and flags appear one cycle later.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    output logic [WIDTH-1:0] res,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    typedef enum logic [2:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_ADD    = 3'b010,
        OP_RSVD   = 3'b011,
        OP_AND_NB = 3'b100,
        OP_OR_NB  = 3'b101,
        OP_SUB    = 3'b110,
        OP_SLT    = 3'b111
    } op_e;

    localparam int MSB = WIDTH - 1;

    op_e              w_op;
    logic [WIDTH-1:0] w_bmux;
    logic             w_cin;
    logic [WIDTH:0]   w_addFull;
    logic [WIDTH-1:0] w_sum;
    logic             w_addCarry;
    logic             w_addOvf;
    logic             w_lessThan;

    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_zero;

    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;
    logic             r_valid;

    assign w_op = op_e'(control);

    // control[2] turns the shared adder into a subtractor: a + ~b + 1.
    assign w_bmux     = control[2] ? ~b : b;
    assign w_cin      = control[2];
    assign w_addFull  = {1'b0, a} + {1'b0, w_bmux} + {{WIDTH{1'b0}}, w_cin};
    assign w_sum      = w_addFull[WIDTH-1:0];
    assign w_addCarry = w_addFull[WIDTH];
    assign w_addOvf   = (a[MSB] == w_bmux[MSB]) && (w_sum[MSB] != a[MSB]);

    // Sign of the difference corrected by overflow keeps SLT right when a-b wraps.
    assign w_lessThan = w_sum[MSB] ^ w_addOvf;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (w_op)
            OP_AND:    w_res = a & b;
            OP_OR:     w_res = a | b;
            OP_ADD: begin
                w_res   = w_sum;
                w_carry = w_addCarry;
                w_ovf   = w_addOvf;
            end
            OP_RSVD:   w_res = '0;
            OP_AND_NB: w_res = a & ~b;
            OP_OR_NB:  w_res = a | ~b;
            OP_SUB: begin
                w_res   = w_sum;
                w_carry = w_addCarry;
                w_ovf   = w_addOvf;
            end
            OP_SLT:    w_res = {{(WIDTH-1){1'b0}}, w_lessThan};
            default:   w_res = '0;
        endcase
    end

    assign w_zero = (w_res == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_res   <= w_res;
                r_carry <= w_carry;
                r_ovf   <= w_ovf;
                r_zero  <= w_zero;
            end
        end
    end

    assign res       = r_res;
    assign carry_out = r_carry;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the 4-bit alu: hand-computed results and flags,
// checked with immediate assertions one cycle after each sampled operation.
module tb_alu;

    localparam logic [2:0] C_AND  = 3'b000;
    localparam logic [2:0] C_OR   = 3'b001;
    localparam logic [2:0] C_ADD  = 3'b010;
    localparam logic [2:0] C_RSVD = 3'b011;
    localparam logic [2:0] C_ANDN = 3'b100;
    localparam logic [2:0] C_ORN  = 3'b101;
    localparam logic [2:0] C_SUB  = 3'b110;
    localparam logic [2:0] C_SLT  = 3'b111;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] control;
    logic [3:0] res;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       out_valid;

    int vectors;
    int miscompares;

    alu #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .control   (control),
        .res       (res),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation, let the DUT sample it, then settle 1 time unit past the edge.
    task automatic applyStimulus(input logic [2:0] ctrl, input logic [3:0] opA,
                                 input logic [3:0] opB, input logic vld);
        control  = ctrl;
        a        = opA;
        b        = opB;
        in_valid = vld;
        vectors++;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expRes,
                               input logic expC, input logic expO,
                               input logic expZ, input logic expV);
        assert (res === expRes) else begin
            miscompares++;
            $error("[TB] FAIL %s res: observed %b expected %b", tag, res, expRes);
        end
        assert (carry_out === expC) else begin
            miscompares++;
            $error("[TB] FAIL %s carry_out: observed %b expected %b", tag, carry_out, expC);
        end
        assert (overflow === expO) else begin
            miscompares++;
            $error("[TB] FAIL %s overflow: observed %b expected %b", tag, overflow, expO);
        end
        assert (zero === expZ) else begin
            miscompares++;
            $error("[TB] FAIL %s zero: observed %b expected %b", tag, zero, expZ);
        end
        assert (out_valid === expV) else begin
            miscompares++;
            $error("[TB] FAIL %s out_valid: observed %b expected %b", tag, out_valid, expV);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        control     = '0;

        // Operation presented while reset is held must be discarded.
        @(posedge clk);
        #1;
        applyStimulus(C_ADD, 4'b0011, 4'b0101, 1'b1);
        checkOutput("reset_hold", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_release_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(C_ADD, 4'b0011, 4'b0101, 1'b1);
        checkOutput("add_3_5", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);

        applyStimulus(C_AND,  4'b1100, 4'b1010, 1'b1);
        checkOutput("and",       4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_OR,   4'b0001, 4'b0011, 1'b1);
        checkOutput("or",        4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_ANDN, 4'b1100, 4'b1010, 1'b1);
        checkOutput("and_not_b", 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_ORN,  4'b0011, 4'b0001, 1'b1);
        checkOutput("or_not_b",  4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_AND,  4'b1111, 4'b0000, 1'b1);
        checkOutput("and_zero",  4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);

        applyStimulus(C_ADD, 4'b1111, 4'b0001, 1'b1);
        checkOutput("add_wrap",    4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(C_ADD, 4'b1000, 4'b1000, 1'b1);
        checkOutput("add_neg_ovf", 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(C_ADD, 4'b1111, 4'b1111, 1'b1);
        checkOutput("add_m1_m1",   4'b1110, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_ADD, 4'b0000, 4'b0000, 1'b1);
        checkOutput("add_0_0",     4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);

        applyStimulus(C_SUB, 4'b0101, 4'b0011, 1'b1);
        checkOutput("sub_5_3",    4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_SUB, 4'b1000, 4'b0011, 1'b1);
        checkOutput("sub_ovf",    4'b0101, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(C_SUB, 4'b0001, 4'b0010, 1'b1);
        checkOutput("sub_borrow", 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_SUB, 4'b0000, 4'b0001, 1'b1);
        checkOutput("sub_0_1",    4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_SUB, 4'b0000, 4'b0000, 1'b1);
        checkOutput("sub_0_0",    4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);

        applyStimulus(C_SLT, 4'b0011, 4'b0110, 1'b1);
        checkOutput("slt_lt",     4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_SLT, 4'b0110, 4'b0011, 1'b1);
        checkOutput("slt_ge",     4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(C_SLT, 4'b1000, 4'b0111, 1'b1);
        checkOutput("slt_ovf",    4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back stream: one result per cycle, then hold when idle.
        applyStimulus(C_ADD, 4'b0010, 4'b0011, 1'b1);
        checkOutput("stream_add", 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_SUB, 4'b0111, 4'b0001, 1'b1);
        checkOutput("stream_sub", 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_SLT, 4'b1111, 4'b0001, 1'b1);
        checkOutput("stream_slt", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(C_ADD, 4'b1111, 4'b1111, 1'b0);
        checkOutput("hold_1",     4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C_SUB, 4'b0000, 4'b0000, 1'b0);
        checkOutput("hold_2",     4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(C_RSVD, 4'b1111, 4'b1111, 1'b1);
        checkOutput("reserved",   4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Load a nonzero result, then assert reset asynchronously between edges.
        applyStimulus(C_SUB, 4'b1000, 4'b0011, 1'b1);
        checkOutput("pre_async",  4'b0101, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(C_OR, 4'b1010, 4'b0101, 1'b0);
        checkOutput("post_reset_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C_OR, 4'b1010, 4'b0101, 1'b1);
        checkOutput("post_reset_or",   4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
